// File: rtl/uart_rx_cfg_pkg.sv
// Shared types for the configurable UART receiver.
//   rx_state_e     : receiver FSM states
//   PAR_*          : parity-mode encodings of cfg_parity (3 also means none)
//   frame_status_t : per-word status flags
//   clamp_data_bits: maps an out-of-range data-bit request to the maximum width
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic break_det;
  } frame_status_t;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input logic [3:0] max_bits);
    if (req < 4'd5 || req > max_bits) return max_bits;
    return req;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_sampler.sv
// Line front end for the UART receiver.
//   clk, rx_rst : clock, asynchronous active-high reset
//   rx          : raw serial line (asynchronous)
//   s_tick      : oversample strobe
//   rx_s        : rx after a 2-flop synchroniser
//   vote        : majority of the last three rx_s samples taken on s_tick
module uart_rx_sampler (
  input  logic clk,
  input  logic rx_rst,
  input  logic rx,
  input  logic s_tick,
  output logic rx_s,
  output logic vote
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;

  // Idle line level is 1, so both stages and the history reset high.
  always_ff @(posedge clk or posedge rx_rst) begin
    if (rx_rst) begin
      sync_q <= 2'b11;
      hist_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], rx};
      if (s_tick) hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  assign rx_s = sync_q[1];
  assign vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampled UART receiver with a one-word holding register.
//   clk, rx_rst      : clock, asynchronous active-high reset
//   rx_en            : receiver enable (low aborts any frame in progress)
//   rx, s_tick       : serial line, oversample strobe
//   cfg_data_bits/cfg_parity/cfg_stop2 : frame format, latched at start detect
//   dout, dout_valid, dout_ready       : received word handshake
//   parity_err, frame_err, break_det   : status of the held word
//   overrun_err      : one-clk pulse when a finished frame is dropped
//   rx_busy          : FSM not idle
//   dbg_state        : current FSM state encoding
//
// Handshake: a word is transferred on any clk where dout_valid and dout_ready
// are both 1. dout and the status flags are stable while dout_valid is 1 and
// keep their values after the transfer until the next word is loaded. A frame
// finishing in the same clk as a transfer is loaded without loss.
module uart_rx_cfg #(
  parameter int DATAWIDTH  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rx_rst,
  input  logic                 rx_en,
  input  logic                 rx,
  input  logic                 s_tick,
  input  logic [3:0]           cfg_data_bits,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err,
  output logic                 rx_busy,
  output logic [2:0]           dbg_state
);
  import uart_pkg::*;

  localparam int              SW     = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0]   S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0]   S_MID  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]      MAXB   = 4'(DATAWIDTH);

  logic rx_s, vote;

  uart_rx_sampler u_sampler (
    .clk    (clk),
    .rx_rst (rx_rst),
    .rx     (rx),
    .s_tick (s_tick),
    .rx_s   (rx_s),
    .vote   (vote)
  );

  rx_state_e            state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [3:0]           nbits_q, nbits_d;
  logic [1:0]           par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic                 bit_q, bit_d;          // voted level of the current bit
  logic                 mid_q, mid_d;          // history holds the mid-bit samples
  logic                 par_zero_q, par_zero_d;
  logic                 done_q, done_d;        // frame committed, waiting for line high
  frame_status_t        pend_q, pend_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d;
  frame_status_t        flags_q, flags_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 commit, load, in_bit, bit_end, par_en;

  assign in_bit  = (state_q != IDLE) && !done_q;
  assign bit_end = in_bit && s_tick && (s_cnt_q == S_LAST);
  assign par_en  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    nbits_d    = nbits_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    bit_d      = bit_q;
    mid_d      = 1'b0;
    par_zero_d = par_zero_q;
    pend_d     = pend_q;
    done_d     = done_q;
    commit     = 1'b0;

    if (in_bit && s_tick) begin
      s_cnt_d = bit_end ? '0 : s_cnt_q + SW'(1);
      mid_d   = (s_cnt_q == S_MID);
    end
    if (in_bit && mid_q) bit_d = vote;

    if (!rx_en) begin
      state_d   = IDLE;
      done_d    = 1'b0;
      s_cnt_d   = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Start detection is level based and does not wait for a tick.
          if (!rx_s) begin
            state_d    = START;
            s_cnt_d    = '0;
            bit_cnt_d  = '0;
            data_d     = '0;
            nbits_d    = clamp_data_bits(cfg_data_bits, MAXB);
            par_d      = cfg_parity;
            stop2_d    = cfg_stop2;
            pend_d     = '0;
            par_zero_d = 1'b1;
          end
        end
        START: begin
          if (mid_q && vote) begin
            state_d = IDLE;
            s_cnt_d = '0;
          end else if (bit_end) begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            // Insert at the top of the active field so the first bit ends at bit 0.
            data_d = (data_q >> 1) | (DATAWIDTH'(bit_q) << (nbits_q - 4'd1));
            if (bit_cnt_q == nbits_q - 4'd1) begin
              bit_cnt_d = '0;
              state_d   = par_en ? PARITY : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            if (bit_q != ((^data_q) ^ (par_q == PAR_ODD))) pend_d.parity_err = 1'b1;
            par_zero_d = !bit_q;
            state_d    = STOP;
          end
        end
        STOP: begin
          if (done_q) begin
            // A held-low line must rise before a new start bit is accepted.
            if (rx_s) begin
              state_d = IDLE;
              done_d  = 1'b0;
            end
          end else if (bit_end) begin
            if (!bit_q) pend_d.frame_err = 1'b1;
            if (bit_cnt_q == 4'd0 && !bit_q && data_q == '0 && par_zero_q)
              pend_d.break_det = 1'b1;
            if (bit_cnt_q == 4'd0 && stop2_q) begin
              bit_cnt_d = 4'd1;
            end else begin
              commit    = 1'b1;
              done_d    = 1'b1;
              bit_cnt_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Holding register: load on commit if empty or being drained this clk,
  // otherwise the finished frame is dropped and flagged.
  always_comb begin
    load    = commit && (!valid_q || dout_ready);
    dout_d  = dout_q;
    flags_d = flags_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (load) begin
      dout_d  = data_q;
      flags_d = pend_d;
      valid_d = 1'b1;
    end else if (commit) begin
      ovr_d = 1'b1;
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q    <= IDLE;
      s_cnt_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      nbits_q    <= '0;
      par_q      <= '0;
      stop2_q    <= 1'b0;
      bit_q      <= 1'b0;
      mid_q      <= 1'b0;
      par_zero_q <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= '0;
      dout_q     <= '0;
      flags_q    <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      nbits_q    <= nbits_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      bit_q      <= bit_d;
      mid_q      <= mid_d;
      par_zero_q <= par_zero_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      dout_q     <= dout_d;
      flags_q    <= flags_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = valid_q;
  assign parity_err  = flags_q.parity_err;
  assign frame_err   = flags_q.frame_err;
  assign break_det   = flags_q.break_det;
  assign overrun_err = ovr_q;
  assign rx_busy     = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames are driven bit by bit on rx, the
// expected word and flags are pushed to exp_q as each frame is sent, and are
// popped and compared when the receiver presents a word.
module tb_uart_rx_cfg;
  localparam int DW      = 8;
  localparam int OS      = 16;
  localparam int EW      = DW + 3;
  localparam int TIMEOUT = 8 * OS;

  logic          clk = 1'b0;
  logic          rx_rst, rx_en, rx, s_tick, cfg_stop2, dout_ready;
  logic [3:0]    cfg_data_bits;
  logic [1:0]    cfg_parity;
  logic [DW-1:0] dout;
  logic          dout_valid, parity_err, frame_err, break_det, overrun_err, rx_busy;
  logic [2:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ovr_cnt  = 0;
  int ovr0;

  uart_rx_cfg #(.DATAWIDTH(DW), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .rx_rst        (rx_rst),
    .rx_en         (rx_en),
    .rx            (rx),
    .s_tick        (s_tick),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .break_det     (break_det),
    .overrun_err   (overrun_err),
    .rx_busy       (rx_busy),
    .dbg_state     (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  always @(negedge clk) if (overrun_err === 1'b1) ovr_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

  // checking / driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One bit period; an optional one-clk inverted spike lands inside the vote window.
  task automatic send_bit(input logic v, input bit spike);
    for (int i = 0; i < OS; i++) begin
      rx = (spike && i == OS / 2 + 2) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [8:0] data, input logic [3:0] cfg_bits,
                            input logic [1:0] pmode, input bit stop2, input bit par_flip,
                            input bit stop_lvl, input bit spikes, input bit push);
    int nb;
    logic [8:0] m;
    logic pc, pb;
    bit pen;
    nb  = (cfg_bits < 4'd5 || int'(cfg_bits) > DW) ? DW : int'(cfg_bits);
    m   = data & ((9'd1 << nb) - 9'd1);
    pen = (pmode == 2'd1) || (pmode == 2'd2);
    pc  = (^m) ^ (pmode == 2'd2);
    pb  = pc ^ par_flip;
    cfg_data_bits = cfg_bits;
    cfg_parity    = pmode;
    cfg_stop2     = stop2;
    if (push)
      exp_q.push_back({m[DW-1:0], pen && (pb != pc), !stop_lvl,
                       (m == 9'd0) && (!pen || !pb) && !stop_lvl});
    send_bit(1'b0, spikes);
    for (int i = 0; i < nb; i++) send_bit(m[i], spikes);
    if (pen) send_bit(pb, spikes);
    send_bit(stop_lvl, spikes);
    if (stop2) send_bit(stop_lvl, spikes);
  endtask

  // Waits for a presented word, compares it with the scoreboard, then drains it.
  task automatic check_word(input string tag);
    logic [EW-1:0] e;
    int w;
    w = 0;
    while (dout_valid !== 1'b1 && w < TIMEOUT) begin
      @(negedge clk);
      w++;
    end
    check({tag, " valid"}, dout_valid, 1);
    check({tag, " sb_nonempty"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, " dout"}, dout, e[EW-1:3]);
      check({tag, " parity_err"}, parity_err, e[2]);
      check({tag, " frame_err"}, frame_err, e[1]);
      check({tag, " break_det"}, break_det, e[0]);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    check({tag, " cleared"}, dout_valid, 0);
  endtask

  // directed sequence
  initial begin
    rx_rst = 1'b1; rx_en = 1'b1; rx = 1'b1; s_tick = 1'b1; dout_ready = 1'b0;
    cfg_data_bits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    repeat (3) @(negedge clk);
    rx_rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset dout", dout, 0);
    check("reset valid", dout_valid, 0);
    check("reset parity_err", parity_err, 0);
    check("reset frame_err", frame_err, 0);
    check("reset break_det", break_det, 0);
    check("reset overrun", overrun_err, 0);
    check("reset busy", rx_busy, 0);

    // 8N1 0xA5
    send_frame(9'h0A5, 4'd8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_word("8n1_a5");
    idle(4);
    check("8n1 busy_returns", rx_busy, 0);
    idle(2 * OS);

    // 7E2 0x3C, good then bad parity
    send_frame(9'h03C, 4'd7, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check_word("7e2_good");
    idle(2 * OS);
    send_frame(9'h03C, 4'd7, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_word("7e2_bad");
    idle(2 * OS);

    // out-of-range width request clamps to 8 bits
    send_frame(9'h0C3, 4'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_word("clamp_3");
    idle(2 * OS);

    // 8O1 with stop bit 0, then line held low for 20 bit times
    ovr0 = ovr_cnt;
    send_frame(9'h05A, 4'd8, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_word("8o1_frame");
    repeat (20 * OS) @(negedge clk);
    check("hold_low busy", rx_busy, 1);
    check("hold_low no_second_word", dout_valid, 0);
    check("hold_low no_overrun", ovr_cnt - ovr0, 0);
    idle(4);
    check("hold_low released", rx_busy, 0);
    idle(2 * OS);

    // break: line low for the whole 8N1 frame
    send_frame(9'h000, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_word("break");
    idle(2 * OS);

    // 4-tick start glitch
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * OS);
    check("glitch busy", rx_busy, 0);
    check("glitch no_word", dout_valid, 0);

    // one-clk spikes inside every bit
    send_frame(9'h00F, 4'd8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_word("spikes");
    idle(2 * OS);

    // rx_en dropped mid-frame
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    rx_en = 1'b0;
    @(negedge clk);
    check("en_abort busy", rx_busy, 0);
    idle(4);
    rx_en = 1'b1;
    idle(2 * OS);
    check("en_abort no_word", dout_valid, 0);

    // overrun: 0x11 held, 0x22 dropped
    ovr0 = ovr_cnt;
    send_frame(9'h011, 4'd8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(2 * OS);
    check("ovr first_held", dout_valid, 1);
    send_frame(9'h022, 4'd8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2 * OS);
    check("ovr pulses", ovr_cnt - ovr0, 1);
    check("ovr dout_kept", dout, 8'h11);
    check("ovr still_valid", dout_valid, 1);
    check_word("ovr_held");
    idle(2 * OS);

    // reset mid-frame with a word held
    send_frame(9'h05A, 4'd8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2 * OS);
    check("rst pre_held", dout_valid, 1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("rst pre_busy", rx_busy, 1);
    rx_rst = 1'b1;
    @(negedge clk);
    check("rst dout", dout, 0);
    check("rst valid", dout_valid, 0);
    check("rst parity_err", parity_err, 0);
    check("rst frame_err", frame_err, 0);
    check("rst break_det", break_det, 0);
    check("rst overrun", overrun_err, 0);
    check("rst busy", rx_busy, 0);
    rx = 1'b1;
    rx_rst = 1'b0;
    idle(2 * OS);
    check("rst no_stray_word", dout_valid, 0);

    check("scoreboard empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Second-generation UART receiver, the successor to the fixed 8N1 receiver.
- Runtime-configurable frame format: data bits, parity and 1 or 2 stop bits.
- Oversampled with majority-vote bit sampling and start-bit glitch rejection.
- Reports parity, framing, break and overrun conditions.
- Sits between the shared baud tick generator (s_tick) and the consumer, which reads received words through a valid/ready holding register.

Parameters:
- DATAWIDTH, 8: maximum data bits per frame; dout width. Legal range 5..9.
- OVERSAMPLE, 16: s_tick pulses per bit period. Even, at least 8.

Ports:
- clk  in  1  system clock.
- rx_rst  in  1  asynchronous active-high reset.
- rx_en  in  1  receiver enable; when low the FSM is held or forced to IDLE.
- rx  in  1  serial input, asynchronous to clk.
- s_tick  in  1  oversample strobe, one clk wide.
- cfg_data_bits  in  4  data bits per frame, 5..DATAWIDTH. Out-of-range values clamp to DATAWIDTH.
- cfg_parity  in  2  parity mode: 0 = none, 1 = even, 2 = odd, 3 = none.
- cfg_stop2  in  1  1 selects two stop bits.
- dout  out  DATAWIDTH  received word, LSB-first on the line, right-aligned, unused upper bits 0.
- dout_valid  out  1  holding register full.
- dout_ready  in  1  consumer accepts the word.
- parity_err  out  1  parity error for the held word.
- frame_err  out  1  a stop bit was sampled 0 for the held word.
- break_det  out  1  break condition for the held word.
- overrun_err  out  1  one-clk pulse when a completed frame is dropped.
- rx_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: state IDLE; dout 0; dout_valid 0; all error flags 0; rx_busy 0; internal counters 0; synchroniser flops 1. Reset is honoured at any point, including mid-frame.
- rx passes through a 2-flop synchroniser; rx_s is the synchronised value.
- Vote sample: on each s_tick, rx_s shifts into a 3-bit history. The vote is the majority of the samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit.
- Tick counter: s_cnt counts s_tick pulses from 0 to OVERSAMPLE-1 within a bit, then wraps. Bit boundaries occur when s_cnt wraps.
- IDLE: when rx_en=1 and rx_s=0, go to START with s_cnt=0. The config inputs are latched at this point and stay stable for the whole frame.
- START: at s_cnt=OVERSAMPLE/2+1, a vote of 1 is a glitch; return to IDLE with no output. Otherwise stay until the bit ends, then go to DATA with bit_cnt=0.
- DATA: at each bit end, shift the vote in at position (cfg_data_bits-1) using right-shift alignment. After the cfg_data_bits-th bit, go to PARITY if parity is enabled, else STOP.
- PARITY: compare the vote against the XOR of the data bits (even) or its inverse (odd). A mismatch sets a pending parity error. At bit end, go to STOP.
- STOP: one or two stop bits. A vote of 0 on any stop bit sets a pending framing error.
- Break: all data bits 0, the parity bit 0 if present, and the first stop vote 0. Break also sets framing error.
- Frame end: at the end of the final stop bit the frame commits.
- Recovery after a framing error: after commit, the FSM waits in STOP until rx_s=1 before returning to IDLE, so a held-low line cannot retrigger reception.
- Commit when dout_valid=0, or when dout_valid=1 and dout_ready=1 in the same cycle: load dout and the flags, set dout_valid=1. This is one cycle of latency from the final stop-bit sample tick.
- Commit when dout_valid=1 and dout_ready=0: drop the new frame, pulse overrun_err for one cycle, and leave the held word and flags unchanged.
- Handshake: dout_valid=1 with dout_ready=1 and no commit clears dout_valid on the next clk. dout, parity_err, frame_err and break_det hold their values until the next load.
- rx_en=0 mid-frame: go to IDLE on the next clk and discard the partial frame. The holding register is unaffected.
- s_tick=0: all counters hold; the FSM advances only on ticks. IDLE start detection does not need a tick.
- Widths: bit_cnt is 4 bits; s_cnt is $clog2(OVERSAMPLE) bits.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - a frame-status struct {parity_err, frame_err, break_det}.
- One sub-module, uart_rx_sampler, holds the 2-flop synchroniser, the 3-sample history shift register and the majority vote. Outputs are rx_s and vote.

Test Plan:
- 8N1, OVERSAMPLE=16, s_tick every clk, send 0xA5 -> dout=0x0A5, dout_valid=1, all error flags 0, rx_busy returns to 0.
- 7E2, send 0x3C with correct parity bit 0 -> dout=0x03C, parity_err=0. Resend with parity bit 1 -> parity_err=1.
- 8O1 with stop bit forced 0 -> frame_err=1. Hold rx=0 for 20 bit times after the frame -> FSM stays out of IDLE, exactly one word is committed.
- Line held at 0 for the whole frame (8N1) -> dout=0x00, break_det=1, frame_err=1.
- rx low pulse of 4 ticks -> returns to IDLE, no dout_valid. One-tick spikes inside a data bit -> the correct bit is still received via the majority vote.
- dout_ready=0, send 0x11 then 0x22 -> dout stays 0x11, overrun_err pulses once. Assert dout_ready -> dout_valid clears. Assert rx_rst mid-frame -> all outputs return to their reset values.
